// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the note drawing controller.
// Holds the FSM state encoding, pipeline latencies and size defaults.
package display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_WAIT_BEAT = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_DRAW      = 3'd4,
        ST_DRAIN     = 3'd5
    } state_t;

    // Issue-to-plot latency of the draw and clear datapaths.
    localparam int DRAW_LAT  = 4;
    localparam int CLEAR_LAT = 2;

    // Note boxes drawn per pass.
    localparam int BOX_COUNT = 3;

    localparam logic [15:0] GRID_LAST_DEF = 16'h7FFF;
    localparam logic [14:0] BOX_LAST_DEF  = 15'd1023;

endpackage

// File: rtl/note_draw_ctrl_strobe_pipe.sv
// strobe_pipe: DEPTH-stage valid shift register, dout = din delayed DEPTH.
// Ports: clock, reset (sync, active-high), din, dout.
module strobe_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clock) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/note_draw_ctrl.sv
// note_draw_ctrl: sequences background clear and per-beat note box redraws.
// Ports: clock, reset (sync, active-high), start, beat, songDone in;
//   shiftSong, loadStartAddress, loadX, loadY, writeToScreen, loadDefault,
//   writeDefault strobes, gridCounter/boxCounter/pixelCount indices,
//   plot, busy, frameDone, overrun out.
// Build option: NOTE_DRAW_CLEAR_EN enables the background clear pass.
module note_draw_ctrl
    import display_pkg::*;
#(
    parameter logic [15:0] GRID_LAST = GRID_LAST_DEF,
    parameter logic [14:0] BOX_LAST  = BOX_LAST_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        beat,
    input  logic        songDone,
    output logic        shiftSong,
    output logic        loadStartAddress,
    output logic        loadX,
    output logic        loadY,
    output logic        writeToScreen,
    output logic        loadDefault,
    output logic        writeDefault,
    output logic [15:0] gridCounter,
    output logic [1:0]  boxCounter,
    output logic [14:0] pixelCount,
    output logic        plot,
    output logic        busy,
    output logic        frameDone,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
`ifdef NOTE_DRAW_CLEAR_EN
    localparam logic [2:0] S_CLEAR = ST_CLEAR;
`endif
    localparam logic [2:0] S_WAIT  = ST_WAIT_BEAT;
    localparam logic [2:0] S_SHIFT = ST_SHIFT;
    localparam logic [2:0] S_DRAW  = ST_DRAW;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;

    localparam logic [1:0] BOX_END = 2'(BOX_COUNT - 1);

    logic [2:0]  state;
    logic [1:0]  boxIdx;
    logic [14:0] pixIdx;
    logic [1:0]  drainCnt;
    logic [1:0]  drainEnd;
    logic        pending;
    logic        doneLatch;
    logic        issueDraw;
    logic        plotDraw;
    logic        plotClr;

`ifdef NOTE_DRAW_CLEAR_EN
    logic [15:0] gridIdx;
`endif

    assign busy = (state != S_IDLE) && (state != S_WAIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            boxIdx     <= '0;
            pixIdx     <= '0;
            pixelCount <= '0;
            drainCnt   <= '0;
            drainEnd   <= '0;
            pending    <= 1'b0;
            doneLatch  <= 1'b0;
            overrun    <= 1'b0;
`ifdef NOTE_DRAW_CLEAR_EN
            gridIdx    <= '0;
`endif
        end else begin
            // Pairs with the start address the datapath registers
            // one cycle after a box begins.
            pixelCount <= pixIdx;

            // Beats that arrive while a pass is running are queued
            // one deep; anything beyond that is dropped and flagged.
            if (busy && beat) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        overrun <= 1'b0;
`ifdef NOTE_DRAW_CLEAR_EN
                        state   <= S_CLEAR;
                        gridIdx <= '0;
`else
                        state   <= S_WAIT;
`endif
                    end
                end
`ifdef NOTE_DRAW_CLEAR_EN
                S_CLEAR: begin
                    if (songDone) begin
                        doneLatch <= 1'b1;
                    end
                    if (gridIdx == GRID_LAST) begin
                        state    <= S_DRAIN;
                        drainCnt <= '0;
                        drainEnd <= 2'(CLEAR_LAT - 1);
                    end else begin
                        gridIdx <= gridIdx + 16'd1;
                    end
                end
`endif
                S_WAIT: begin
                    if (songDone) begin
                        state   <= S_IDLE;
                        pending <= 1'b0;
                    end else if (beat || pending) begin
                        state   <= S_SHIFT;
                        // A fresh beat landing on a queued one stays queued.
                        pending <= pending & beat;
                    end
                end
                S_SHIFT: begin
                    if (songDone) begin
                        doneLatch <= 1'b1;
                    end
                    state  <= S_DRAW;
                    boxIdx <= '0;
                    pixIdx <= '0;
                end
                S_DRAW: begin
                    if (songDone) begin
                        doneLatch <= 1'b1;
                    end
                    if (pixIdx == BOX_LAST) begin
                        if (boxIdx == BOX_END) begin
                            state    <= S_DRAIN;
                            drainCnt <= '0;
                            drainEnd <= 2'(DRAW_LAT - 1);
                        end else begin
                            boxIdx <= boxIdx + 2'd1;
                            pixIdx <= '0;
                        end
                    end else begin
                        pixIdx <= pixIdx + 15'd1;
                    end
                end
                S_DRAIN: begin
                    if (drainCnt == drainEnd) begin
                        if (doneLatch) begin
                            state     <= S_IDLE;
                            doneLatch <= 1'b0;
                            pending   <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        drainCnt <= drainCnt + 2'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign issueDraw        = (state == S_DRAW);
    assign shiftSong        = (state == S_SHIFT);
    assign loadStartAddress = issueDraw && (pixIdx == '0);
    assign boxCounter       = boxIdx;
    // Last drain cycle coincides with the final plot leaving the pipe.
    assign frameDone        = (state == S_DRAIN) && (drainCnt == drainEnd);

    strobe_pipe #(.DEPTH(DRAW_LAT - 2)) u_drawXY (
        .clock (clock),
        .reset (reset),
        .din   (issueDraw),
        .dout  (loadX)
    );

    assign loadY = loadX;

    strobe_pipe #(.DEPTH(DRAW_LAT - 1)) u_drawWr (
        .clock (clock),
        .reset (reset),
        .din   (issueDraw),
        .dout  (writeToScreen)
    );

    strobe_pipe #(.DEPTH(DRAW_LAT)) u_drawPlot (
        .clock (clock),
        .reset (reset),
        .din   (issueDraw),
        .dout  (plotDraw)
    );

`ifdef NOTE_DRAW_CLEAR_EN
    assign loadDefault = (state == S_CLEAR);
    assign gridCounter = gridIdx;

    strobe_pipe #(.DEPTH(CLEAR_LAT - 1)) u_clrWr (
        .clock (clock),
        .reset (reset),
        .din   (loadDefault),
        .dout  (writeDefault)
    );

    strobe_pipe #(.DEPTH(CLEAR_LAT)) u_clrPlot (
        .clock (clock),
        .reset (reset),
        .din   (loadDefault),
        .dout  (plotClr)
    );
`else
    assign loadDefault  = 1'b0;
    assign writeDefault = 1'b0;
    assign gridCounter  = '0;
    assign plotClr      = 1'b0;
`endif

    assign plot = plotDraw | plotClr;

endmodule

// File: tb/tb_note_draw_ctrl.sv
// tb_note_draw_ctrl: directed and random beats against a schedule model.
// Works with and without NOTE_DRAW_CLEAR_EN.
`timescale 1ns/1ps
module tb_note_draw_ctrl;

    localparam logic [15:0] GL = 16'd15;
    localparam logic [14:0] BL = 15'd3;
    localparam int G    = 15;
    localparam int B    = 4;
    localparam int NP   = 3 * B;
    localparam int MAXC = 4096;
`ifdef NOTE_DRAW_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        beat = 1'b0;
    logic        songDone = 1'b0;
    logic        shiftSong, loadStartAddress, loadX, loadY;
    logic        writeToScreen, loadDefault, writeDefault;
    logic [15:0] gridCounter;
    logic [1:0]  boxCounter;
    logic [14:0] pixelCount;
    logic        plot, busy, frameDone, overrun;

    note_draw_ctrl #(.GRID_LAST(GL), .BOX_LAST(BL)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .beat             (beat),
        .songDone         (songDone),
        .shiftSong        (shiftSong),
        .loadStartAddress (loadStartAddress),
        .loadX            (loadX),
        .loadY            (loadY),
        .writeToScreen    (writeToScreen),
        .loadDefault      (loadDefault),
        .writeDefault     (writeDefault),
        .gridCounter      (gridCounter),
        .boxCounter       (boxCounter),
        .pixelCount       (pixelCount),
        .plot             (plot),
        .busy             (busy),
        .frameDone        (frameDone),
        .overrun          (overrun)
    );

    always #5 clock = ~clock;

    // Expected per-cycle values, indexed by cycle number.
    bit eLd[MAXC], eWd[MAXC], ePlot[MAXC], eShift[MAXC];
    bit eLsa[MAXC], eLxy[MAXC], eWs[MAXC], eFd[MAXC];
    bit mGrid[MAXC], mBox[MAXC], mPix[MAXC];
    int eGrid[MAXC], eBox[MAXC], ePix[MAXC];

    // Session-level model state.
    int cyc = 0;
    bit mActive = 0, mPend = 0, mOvr = 0, mDone = 0;
    int busyEnd = -1, drainStart = -1;

    int nCmp = 0, nBad = 0;
    int plotCnt = 0, fdCnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h cycle %0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic schedDraw(input int n);
        eShift[n] = 1;
        for (int j = 0; j < NP; j++) begin
            int t;
            t = n + 1 + j;
            eBox[t] = j / B;
            mBox[t] = 1;
            if (j % B == 0) eLsa[t] = 1;
            ePix[t+1] = j % B;
            mPix[t+1] = 1;
            eLxy[t+2] = 1;
            eWs[t+3] = 1;
            ePlot[t+4] = 1;
        end
        eFd[n+NP+4] = 1;
        busyEnd = n + NP + 4;
        drainStart = n + NP + 1;
    endtask

    task automatic schedClear(input int n);
        for (int i = 0; i <= G; i++) begin
            eLd[n+i] = 1;
            eGrid[n+i] = i;
            mGrid[n+i] = 1;
            eWd[n+i+1] = 1;
            ePlot[n+i+2] = 1;
        end
        eFd[n+G+2] = 1;
        busyEnd = n + G + 2;
        drainStart = n + G + 1;
    endtask

    // n is the cycle that begins at the edge where inputs were sampled.
    task automatic stepModel(input int n, input bit st, input bit bt,
                             input bit sd, input bit rs);
        if (rs) begin
            for (int k = n; k < n + 64; k++) begin
                eLd[k] = 0; eWd[k] = 0; ePlot[k] = 0; eShift[k] = 0;
                eLsa[k] = 0; eLxy[k] = 0; eWs[k] = 0; eFd[k] = 0;
                mGrid[k] = 0; mBox[k] = 0; mPix[k] = 0;
                eGrid[k] = 0; eBox[k] = 0; ePix[k] = 0;
            end
            mActive = 0; mPend = 0; mOvr = 0; mDone = 0;
            busyEnd = -1; drainStart = -1;
            mGrid[n] = 1; mBox[n] = 1; mPix[n] = 1;
        end else if (!mActive) begin
            if (st) begin
                mOvr = 0;
                mActive = 1;
                if (CLR) schedClear(n);
                else busyEnd = n - 1;
            end
        end else if (n - 1 > busyEnd) begin
            if (sd) begin
                mActive = 0;
                mPend = 0;
            end else if (bt || mPend) begin
                mPend = mPend && bt;
                schedDraw(n);
            end
        end else begin
            if (bt) begin
                if (mPend) mOvr = 1;
                else mPend = 1;
            end
            if (sd && n - 1 < drainStart) mDone = 1;
            if (n - 1 == busyEnd && mDone) begin
                mActive = 0;
                mDone = 0;
                mPend = 0;
            end
        end
    endtask

    task automatic checkCycle(input int n);
        chk("plot", 32'(plot), 32'(ePlot[n]));
        chk("loadDefault", 32'(loadDefault), 32'(eLd[n]));
        chk("writeDefault", 32'(writeDefault), 32'(eWd[n]));
        chk("shiftSong", 32'(shiftSong), 32'(eShift[n]));
        chk("loadStartAddress", 32'(loadStartAddress), 32'(eLsa[n]));
        chk("loadX", 32'(loadX), 32'(eLxy[n]));
        chk("loadY", 32'(loadY), 32'(eLxy[n]));
        chk("writeToScreen", 32'(writeToScreen), 32'(eWs[n]));
        chk("frameDone", 32'(frameDone), 32'(eFd[n]));
        chk("overrun", 32'(overrun), 32'(mOvr));
        chk("busy", 32'(busy), 32'(mActive && n <= busyEnd));
        chk("strobeOverlap", 32'(writeDefault & writeToScreen), 32'd0);
        if (mBox[n]) chk("boxCounter", 32'(boxCounter), 32'(eBox[n]));
        if (mPix[n]) chk("pixelCount", 32'(pixelCount), 32'(ePix[n]));
        if (!CLR || mGrid[n])
            chk("gridCounter", 32'(gridCounter), 32'(eGrid[n]));
    endtask

    task automatic tick(input bit st, input bit bt, input bit sd,
                        input bit rs);
        @(negedge clock);
        start = st;
        beat = bt;
        songDone = sd;
        reset = rs;
        @(posedge clock);
        cyc++;
        stepModel(cyc, st, bt, sd, rs);
        #1;
        checkCycle(cyc);
        plotCnt += int'(plot);
        fdCnt += int'(frameDone);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(0, 0, 0, 0);
    endtask

    initial begin
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("resetAllZero", {14'd0, shiftSong, loadStartAddress, loadX,
            loadY, writeToScreen, loadDefault, writeDefault, gridCounter,
            boxCounter, pixelCount, plot, busy, frameDone, overrun}, 32'd0);

        // Session start, with clear pass when built in.
        plotCnt = 0; fdCnt = 0;
        tick(1, 0, 0, 0);
        idle(G + 4);
        chk("startPlots", 32'(plotCnt), CLR ? 32'(G + 1) : 32'd0);
        chk("startFrameDone", 32'(fdCnt), CLR ? 32'd1 : 32'd0);
        chk("startBusyAfter", 32'(busy), 32'd0);

        // Single draw pass.
        plotCnt = 0; fdCnt = 0;
        tick(0, 1, 0, 0);
        idle(NP + 6);
        chk("drawPlots", 32'(plotCnt), 32'(NP));
        chk("drawFrameDone", 32'(fdCnt), 32'd1);

        // Queued beat, then an overrun in the same pass.
        plotCnt = 0; fdCnt = 0;
        tick(0, 1, 0, 0);
        idle(5);
        tick(0, 1, 0, 0);
        idle(2);
        tick(0, 1, 0, 0);
        chk("overrunSet", 32'(overrun), 32'd1);
        idle(2 * (NP + 6));
        chk("queuedPlots", 32'(plotCnt), 32'(2 * NP));
        chk("queuedFrameDone", 32'(fdCnt), 32'd2);

        // songDone mid-draw finishes the pass, then beats are ignored.
        plotCnt = 0;
        tick(0, 1, 0, 0);
        idle(4);
        tick(0, 0, 1, 0);
        idle(NP + 4);
        chk("songDonePlots", 32'(plotCnt), 32'(NP));
        chk("songDoneBusy", 32'(busy), 32'd0);
        plotCnt = 0;
        tick(0, 1, 0, 0);
        idle(NP + 6);
        chk("idleBeatPlots", 32'(plotCnt), 32'd0);
        chk("overrunHeld", 32'(overrun), 32'd1);

        // New session clears overrun.
        tick(1, 0, 0, 0);
        chk("overrunCleared", 32'(overrun), 32'd0);
        idle(G + 4);

        // Reset in the fifth draw cycle.
        tick(0, 1, 0, 0);
        idle(5);
        tick(0, 0, 0, 1);
        chk("midResetZero", {14'd0, shiftSong, loadStartAddress, loadX,
            loadY, writeToScreen, loadDefault, writeDefault, gridCounter,
            boxCounter, pixelCount, plot, busy, frameDone, overrun}, 32'd0);
        plotCnt = 0;
        idle(6);
        chk("midResetNoPlot", 32'(plotCnt), 32'd0);

        // Random traffic.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 31) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 299) == 0);
        end
        idle(NP + G + 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
